// File: rtl/sdram_log_pkg.sv
// rtl/sdram_log_pkg.sv - shared commands, record layout, FSM states and address split for the sample logger
package sdram_log_pkg;

  localparam logic [1:0] CMD_IDLE    = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_REFRESH = 2'b11;

  localparam int RECORD_WORDS = 3;
  localparam logic [7:0] HDR_MARK = 8'hA5;

  localparam int BANK_W   = 2;
  localparam int ROW_W    = 13;
  localparam int COL_W    = 9;
  localparam int ADDR_W   = BANK_W + ROW_W + COL_W;
  localparam int TS_W     = 24;
  localparam int SAMPLE_W = 16;
  localparam int ENTRY_W  = TS_W + SAMPLE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } sdram_addr_t;

  function automatic sdram_addr_t split_addr(input logic [ADDR_W-1:0] a);
    sdram_addr_t r;
    r.bank = a[23:22];
    r.row  = a[21:9];
    r.col  = a[8:0];
    return r;
  endfunction

  // entry layout is {timestamp, sample}
  function automatic logic [SAMPLE_W-1:0] record_word(input logic [1:0] idx,
                                                       input logic [ENTRY_W-1:0] entry);
    case (idx)
      2'd0:    return {HDR_MARK, entry[39:32]};
      2'd1:    return entry[31:16];
      default: return entry[15:0];
    endcase
  endfunction

endpackage

// File: rtl/sdram_log_fifo.sv
// rtl/sdram_log_fifo.sv - synchronous sample FIFO, DEPTH (power of two) entries with full/empty/count
module sdram_log_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 40,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sdram_log_writer.sv
// rtl/sdram_log_writer.sv - timestamped sample logger feeding sdram_interface; SDRAM_LOG_WRAP_EN wraps at END_ADDR
module sdram_log_writer
  import sdram_log_pkg::*;
#(
  parameter int              FIFO_DEPTH     = 4,
  parameter logic [23:0]     END_ADDR       = 24'hFFFFFF,
  parameter int              TIMEOUT_CYCLES = 4800
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET,
  input  logic [23:0] TIMESTAMP,
  input  logic [15:0] SAMPLE_IN,
  input  logic        SAMPLE_VALID,
  output logic        SAMPLE_READY,
  input  logic        STATUS,
  output logic [1:0]  A_IN_BANK,
  output logic [12:0] A_IN_ROW,
  output logic [8:0]  A_IN_COL,
  output logic [15:0] D_IN,
  output logic [1:0]  CMD_IN,
  output logic [23:0] WR_PTR,
  output logic        OVERFLOW,
  output logic        MEM_FULL,
  output logic        TIMEOUT_ERR
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [ENTRY_W-1:0] fifo_data;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]      fifo_count;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [ENTRY_W-1:0] rec_q, rec_d;
  logic [ADDR_W-1:0]  base_q, base_d, wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [1:0]         cmd_q, cmd_d;
  sdram_addr_t        addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic               ovf_q, ovf_d, mem_full_q, mem_full_d, tmo_err_q, tmo_err_d;
  logic               room, tmo_hit;

  sdram_log_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk       (CLK_48MHZ),
    .reset     (RESET),
    .push      (SAMPLE_VALID),
    .push_data ({TIMESTAMP, SAMPLE_IN}),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign room    = ({1'b0, wr_ptr_q} + 25'd2) <= {1'b0, END_ADDR};
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rec_d      = rec_q;
    base_d     = base_q;
    wr_ptr_d   = wr_ptr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ovf_d      = ovf_q;
    mem_full_d = mem_full_q;
    tmo_err_d  = tmo_err_q;
    fifo_pop   = 1'b0;

    if (SAMPLE_VALID && fifo_full) ovf_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (mem_full_q) begin
            fifo_pop = 1'b1;
            ovf_d    = 1'b1;
          end else if (!room) begin
`ifdef SDRAM_LOG_WRAP_EN
            wr_ptr_d = '0;
`else
            mem_full_d = 1'b1;
            fifo_pop   = 1'b1;
            ovf_d      = 1'b1;
`endif
          end else if (!STATUS) begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        rec_d    = fifo_data;
        idx_d    = 2'd0;
        base_d   = wr_ptr_q;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (STATUS) begin
          state_d = ST_WAIT;
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          wr_ptr_d  = base_q + ADDR_W'(RECORD_WORDS);
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!STATUS) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (idx_q < 2'(RECORD_WORDS - 1)) begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          wr_ptr_d  = base_q + ADDR_W'(RECORD_WORDS);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // the watchdog restarts whenever a state is (re)entered, including WAIT -> ISSUE
    if (state_d != state_q || (state_q != ST_ISSUE && state_q != ST_WAIT)) tmo_d = '0;
    else                                                               tmo_d = tmo_q + 1'b1;

    // outputs are registered, so they are loaded from next-state values to appear in the ISSUE cycle
    cmd_d = (state_d == ST_ISSUE) ? CMD_WRITE : CMD_IDLE;
    if (state_d == ST_ISSUE) begin
      addr_d = split_addr(wr_ptr_d);
      data_d = record_word(idx_d, rec_d);
    end
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      rec_q      <= '0;
      base_q     <= '0;
      wr_ptr_q   <= '0;
      tmo_q      <= '0;
      cmd_q      <= CMD_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      mem_full_q <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rec_q      <= rec_d;
      base_q     <= base_d;
      wr_ptr_q   <= wr_ptr_d;
      tmo_q      <= tmo_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      mem_full_q <= mem_full_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign SAMPLE_READY = (fifo_count < CW'(FIFO_DEPTH));
  assign A_IN_BANK    = addr_q.bank;
  assign A_IN_ROW     = addr_q.row;
  assign A_IN_COL     = addr_q.col;
  assign D_IN         = data_q;
  assign CMD_IN       = cmd_q;
  assign WR_PTR       = wr_ptr_q;
  assign OVERFLOW     = ovf_q;
  assign MEM_FULL     = mem_full_q;
  assign TIMEOUT_ERR  = tmo_err_q;

endmodule

// File: tb/tb_sdram_log_writer.sv
// tb/tb_sdram_log_writer.sv - directed bench for sdram_log_writer with a busy-pulse STATUS model
module tb_sdram_log_writer;
  import sdram_log_pkg::*;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_a, sv_a, st_a, rdy_a, ovf_a, mf_a, te_a;
  logic [23:0] ts_a, ptr_a;
  logic [15:0] sd_a, din_a;
  logic [1:0]  bank_a, cmd_a;
  logic [12:0] row_a;
  logic [8:0]  col_a;

  logic        rst_b, sv_b, st_b, rdy_b, ovf_b, mf_b, te_b;
  logic [23:0] ts_b, ptr_b;
  logic [15:0] sd_b, din_b;
  logic [1:0]  bank_b, cmd_b;
  logic [12:0] row_b;
  logic [8:0]  col_b;

  sdram_log_writer #(.FIFO_DEPTH(4)) dut_a (
    .CLK_48MHZ(clk), .RESET(rst_a), .TIMESTAMP(ts_a), .SAMPLE_IN(sd_a),
    .SAMPLE_VALID(sv_a), .SAMPLE_READY(rdy_a), .STATUS(st_a),
    .A_IN_BANK(bank_a), .A_IN_ROW(row_a), .A_IN_COL(col_a), .D_IN(din_a),
    .CMD_IN(cmd_a), .WR_PTR(ptr_a), .OVERFLOW(ovf_a), .MEM_FULL(mf_a),
    .TIMEOUT_ERR(te_a));

  sdram_log_writer #(.FIFO_DEPTH(4), .END_ADDR(24'h000005), .TIMEOUT_CYCLES(16)) dut_b (
    .CLK_48MHZ(clk), .RESET(rst_b), .TIMESTAMP(ts_b), .SAMPLE_IN(sd_b),
    .SAMPLE_VALID(sv_b), .SAMPLE_READY(rdy_b), .STATUS(st_b),
    .A_IN_BANK(bank_b), .A_IN_ROW(row_b), .A_IN_COL(col_b), .D_IN(din_b),
    .CMD_IN(cmd_b), .WR_PTR(ptr_b), .OVERFLOW(ovf_b), .MEM_FULL(mf_b),
    .TIMEOUT_ERR(te_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [23:0] ts, input logic [15:0] s, input int w);
    case (w)
      0:       return {8'hA5, ts[23:16]};
      1:       return ts[15:0];
      default: return s;
    endcase
  endfunction

  // SDRAM-side model: accepts a write when idle, then stays busy for busy_x cycles
  int          busy_a = 4, cnt_a = 0, wcyc_a = 0;
  logic [23:0] la_a[$];
  logic [15:0] ld_a[$];
  initial begin
    st_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cmd_a == CMD_WRITE) wcyc_a++;
      if (cnt_a > 0) begin
        cnt_a--;
        if (cnt_a == 0) st_a = 1'b0;
      end else if (cmd_a == CMD_WRITE && !st_a) begin
        la_a.push_back({bank_a, row_a, col_a});
        ld_a.push_back(din_a);
        st_a  = 1'b1;
        cnt_a = busy_a;
      end
    end
  end

  int          busy_b = 2, cnt_b = 0, wcyc_b = 0;
  bit          stuck_b = 1'b0;
  logic [23:0] la_b[$];
  logic [15:0] ld_b[$];
  initial begin
    st_b = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cmd_b == CMD_WRITE) wcyc_b++;
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) st_b = 1'b0;
      end else if (cmd_b == CMD_WRITE && !st_b && !stuck_b) begin
        la_b.push_back({bank_b, row_b, col_b});
        ld_b.push_back(din_b);
        st_b  = 1'b1;
        cnt_b = busy_b;
      end
    end
  end

  initial begin
    sdram_addr_t sa;
    bit          saw_low;
    int          n_exp;
    logic [23:0] t;
    logic [15:0] s;

    rst_a = 1'b1; rst_b = 1'b1;
    sv_a = 1'b0; sv_b = 1'b0;
    ts_a = '0; ts_b = '0; sd_a = '0; sd_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(rdy_a), 64'd1);
    chk("rst_cmd",   64'(cmd_a), 64'd0);
    chk("rst_ptr",   64'(ptr_a), 64'd0);
    chk("rst_flags", 64'({ovf_a, mf_a, te_a}), 64'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // single sample, three words at 0..2
    wcyc_a = 0;
    sv_a = 1'b1; ts_a = 24'h123456; sd_a = 16'h0001;
    @(negedge clk);
    sv_a = 1'b0;
    repeat (60) @(negedge clk);
    chk("t1_nwords", 64'(la_a.size()), 64'd3);
    if (la_a.size() >= 3) begin
      chk("t1_w0", {la_a[0], ld_a[0]}, {24'd0, 16'hA512});
      chk("t1_w1", {la_a[1], ld_a[1]}, {24'd1, 16'h3456});
      chk("t1_w2", {la_a[2], ld_a[2]}, {24'd2, 16'h0001});
    end
    chk("t1_ptr",  64'(ptr_a), 64'd3);
    chk("t1_wcyc", 64'(wcyc_a), 64'd3);
    chk("t1_cmd",  64'(cmd_a), 64'd0);

    // six back-to-back samples against a slow SDRAM
    busy_a = 20;
    la_a.delete(); ld_a.delete();
    saw_low = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sv_a = 1'b1; ts_a = 24'h0A0B00 + 24'(i); sd_a = 16'hC000 + 16'(i);
      @(negedge clk);
      if (!rdy_a) saw_low = 1'b1;
    end
    sv_a = 1'b0;
    repeat (500) @(negedge clk);
    chk("t2_ready_low", 64'(saw_low), 64'd1);
    chk("t2_overflow",  64'(ovf_a), 64'd1);
    chk("t2_nwords",    64'(la_a.size()), 64'd15);
    chk("t2_ptr",       64'(ptr_a), 64'd18);
    for (int i = 0; i < 15; i++) begin
      if (i < la_a.size()) begin
        t = 24'h0A0B00 + 24'(i / 3);
        s = 16'hC000 + 16'(i / 3);
        chk($sformatf("t2_word%0d", i), {la_a[i], ld_a[i]}, {24'(3 + i), exp_word(t, s, i % 3)});
      end
    end

    // reset while the first word is still in WAIT
    sv_a = 1'b1; ts_a = 24'h777777; sd_a = 16'h7777;
    @(negedge clk);
    sv_a = 1'b0;
    repeat (8) @(negedge clk);
    chk("t3_in_wait", 64'({st_a, cmd_a}), {62'd0, 1'b1, 1'b0} >> 0 == 64'd0 ? 64'd0 : 64'h4);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("t3_cmd",   64'(cmd_a), 64'd0);
    chk("t3_ptr",   64'(ptr_a), 64'd0);
    chk("t3_flags", 64'({ovf_a, mf_a, te_a}), 64'd0);
    chk("t3_ready", 64'(rdy_a), 64'd1);

    // END_ADDR = 5: two records fit, the third hits the end
    for (int i = 0; i < 3; i++) begin
      sv_b = 1'b1; ts_b = 24'h00AB00 + 24'(i); sd_b = 16'h5000 + 16'(i);
      @(negedge clk);
    end
    sv_b = 1'b0;
    repeat (200) @(negedge clk);
`ifdef SDRAM_LOG_WRAP_EN
    n_exp = 9;
    chk("t4_ptr",      64'(ptr_b), 64'd3);
    chk("t4_memfull",  64'(mf_b), 64'd0);
    chk("t4_overflow", 64'(ovf_b), 64'd0);
`else
    n_exp = 6;
    chk("t4_ptr",      64'(ptr_b), 64'd6);
    chk("t4_memfull",  64'(mf_b), 64'd1);
    chk("t4_overflow", 64'(ovf_b), 64'd1);
`endif
    chk("t4_nwords", 64'(la_b.size()), 64'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      if (i < la_b.size()) begin
        t = 24'h00AB00 + 24'(i / 3);
        s = 16'h5000 + 16'(i / 3);
        chk($sformatf("t4_word%0d", i), {la_b[i], ld_b[i]}, {24'(i % 6), exp_word(t, s, i % 3)});
      end
    end

    // STATUS never answers: watchdog abandons the record after 16 ISSUE cycles
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    stuck_b = 1'b1; wcyc_b = 0;
    la_b.delete(); ld_b.delete();
    sv_b = 1'b1; ts_b = 24'h0000AA; sd_b = 16'hBEEF;
    @(negedge clk);
    sv_b = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_early_err", 64'(te_b), 64'd0);
    chk("t5_early_cmd", 64'(cmd_b), 64'(CMD_WRITE));
    repeat (30) @(negedge clk);
    chk("t5_err",    64'(te_b), 64'd1);
    chk("t5_cmd",    64'(cmd_b), 64'd0);
    chk("t5_ptr",    64'(ptr_b), 64'd3);
    chk("t5_wcyc",   64'(wcyc_b), 64'd16);
    chk("t5_nwords", 64'(la_b.size()), 64'd0);

    // linear address split at a high address
    sa = split_addr(24'h7FFFFE);
    chk("split_bank", 64'(sa.bank), 64'd1);
    chk("split_row",  64'(sa.row), 64'h1FFF);
    chk("split_col",  64'(sa.col), 64'h1FE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_log_writer.md
Name: sdram_log_writer

Overview:
- Upstream feeder for sdram_interface: accepts 16-bit sensor samples, tags each with the 24-bit TIMESTAMP, and writes them to SDRAM as sequential 3-word records.
- Drives A_IN_BANK/A_IN_COL/A_IN_ROW, D_IN and CMD_IN of sdram_interface; paces itself on its STATUS output.
- Owns the linear write pointer, small input FIFO, overflow/full/timeout reporting.

Parameters:
- FIFO_DEPTH, 4, sample FIFO entries (power of 2, >=2).
- END_ADDR, 24'hFFFFFF, last linear word address usable ({bank,row,col}).
- TIMEOUT_CYCLES, 4800, max CLK_48MHZ cycles waiting on any STATUS edge (100 us).

Ports:
- CLK_48MHZ  in  1  system clock, 48 MHz.
- RESET  in  1  synchronous, active-high reset.
- TIMESTAMP  in  24  free-running time count.
- SAMPLE_IN  in  16  sample data.
- SAMPLE_VALID  in  1  sample present this cycle.
- SAMPLE_READY  out  1  FIFO not full; sample taken when VALID&READY.
- STATUS  in  1  from sdram_interface: 1 = busy.
- A_IN_BANK  out  2  bank address.
- A_IN_ROW  out  13  row address.
- A_IN_COL  out  9  column address.
- D_IN  out  16  write data.
- CMD_IN  out  2  command to sdram_interface.
- WR_PTR  out  24  next linear word address.
- OVERFLOW  out  1  sticky: sample dropped (FIFO full or memory full).
- MEM_FULL  out  1  sticky: END_ADDR written, logging stopped.
- TIMEOUT_ERR  out  1  sticky: STATUS handshake timed out.

Behaviour:
- Reset: all outputs 0 except SAMPLE_READY=1; CMD_IN=CMD_IDLE; FIFO empty; FSM IDLE; WR_PTR=0. RESET mid-transfer aborts immediately; CMD_IN idle next cycle.
- FIFO entry = {TIMESTAMP captured on accept cycle, SAMPLE_IN} (40 bits). Write when VALID&READY; VALID while full sets OVERFLOW, sample discarded. Simultaneous push/pop on full FIFO: pop frees slot only next cycle (READY is registered from count).
- Record words: W0={8'hA5, TS[23:16]}, W1=TS[15:0], W2=SAMPLE. Linear address A -> bank=A[23:22], row=A[21:9], col=A[8:0].
- FSM: IDLE -> (FIFO not empty, !MEM_FULL, STATUS=0) LOAD: pop, word index=0 -> ISSUE: drive addr/D_IN, CMD_IN=CMD_WRITE, hold until STATUS=1 -> WAIT: CMD_IN=CMD_IDLE, hold addr/data until STATUS=0 -> WR_PTR+1; if index<2 index+1, ISSUE; else IDLE.
- Minimum per-word latency: ISSUE entered 1 cycle after LOAD; CMD_IN visible in ISSUE cycle.
- Timeout: counter resets on each state entry; reaching TIMEOUT_CYCLES in ISSUE or WAIT sets TIMEOUT_ERR, CMD_IN idle, record abandoned, WR_PTR advanced to next record boundary, return IDLE.
- Memory end: a record starts only if WR_PTR+2 <= END_ADDR; otherwise MEM_FULL=1 (unless wrap enabled); FIFO then drains discarding, each discard sets OVERFLOW.
- Sticky flags cleared only by RESET.

Optional Feature:
- Macro SDRAM_LOG_WRAP_EN.
- Defined: when record would exceed END_ADDR, WR_PTR wraps to 0 and logging continues; MEM_FULL never set; set instead a sticky internal wrap bit output on MEM_FULL? No — MEM_FULL stays 0, WR_PTR wrap observable.
- Undefined: stop-at-end behaviour above.

Decomposition:
- Package sdram_log_pkg: CMD_IDLE=2'b00, CMD_READ=2'b01, CMD_WRITE=2'b10, CMD_REFRESH=2'b11; RECORD_WORDS=3; HDR_MARK=8'hA5; FSM state encoding; address field widths (2/13/9).
- One sub-module: sdram_log_fifo (synchronous FIFO, FIFO_DEPTH x 40, full/empty/count).

Test Plan:
- Single sample 16'h0001 at TIMESTAMP 24'h123456, STATUS model busy 4 cycles -> writes 16'hA512 @0, 16'h3456 @1, 16'h0001 @2; WR_PTR=3; CMD_IN=2'b10 only in ISSUE.
- 6 back-to-back samples, STATUS busy 20 cycles, FIFO_DEPTH=4 -> SAMPLE_READY drops, OVERFLOW=1, first 4+1 samples logged in order.
- END_ADDR=24'h000005, 3 samples -> 2 records written, MEM_FULL=1, 3rd sample dropped, OVERFLOW=1; with SDRAM_LOG_WRAP_EN 3rd record at 0..2.
- STATUS stuck 0 in ISSUE, TIMEOUT_CYCLES=16 -> TIMEOUT_ERR after 16 cycles, CMD_IN idle, WR_PTR=3.
- Address split: WR_PTR=24'h7FFFFE write -> bank=1, row=13'h1FFF, col=9'h1FE.
- RESET asserted during WAIT -> next cycle CMD_IN=0, WR_PTR=0, flags 0, SAMPLE_READY=1.
